interpo_coef_reader: RTL and testbench

- Avalon-MM read master for the second (s2) port of a 40 x 32-bit interpolation coefficient on-chip RAM.
- On a start pulse, fetches a contiguous block of coefficient words and presents them as a packetised Avalon-ST source with valid/ready backpressure.
- Sits between the Qsys coefficient table and the interpolation datapath, so the datapath never addresses the RAM directly.

---
 rtl/interpo_coef_reader.sv | 184 ++++++++++++++++++
 tb/tb_interpo_coef_reader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interpo_coef_reader.sv
`default_nettype none
// ============================================================================
// Module   : interpo_coef_reader
// Purpose  : Avalon-MM read master for port s2 of the interpolation
//            coefficient RAM. A start pulse fetches a contiguous block of
//            coefficient words and re-emits them as a packetised Avalon-ST
//            source (sop/eop, valid/ready backpressure).
// Ports    : clk, reset_n (async, active low)
//            start/base_addr/num_words   - block request, sampled in IDLE
//            busy/done/cfg_err           - status (done, cfg_err are pulses)
//            mem_*                       - Avalon-MM read port to the RAM
//            src_*                       - Avalon-ST source to the datapath
// Options  : define INTERPO_COEF_READER_WRAP_EN to let addresses wrap
//            modulo DEPTH instead of rejecting blocks that run off the end.
// Revision : 1.0 - initial release
// ============================================================================
module interpo_coef_reader #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 40,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q;
    logic [ADDR_W:0]     num_q;
    logic [ADDR_W:0]     issued_q;
    logic [ADDR_W:0]     wr_idx_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                cs_q;       // read strobe presented to the RAM this cycle
    logic                rv_q;       // readdata valid this cycle (1-cycle pipeline bit)
    logic                busy_q;
    logic                done_q;
    logic                cfg_err_q;
    // FIFO entry layout: {sop, eop, data}
    logic [DATA_W+1:0]   fifo_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  wr_ptr_q;
    logic [c_PTR_W-1:0]  rd_ptr_q;
    logic [c_CNT_W-1:0]  count_q;

    logic                start_ok_d;
    logic [ADDR_W-1:0]   next_addr_d;
    logic [c_CNT_W:0]    occ_d;
    logic                issue_d;
    logic                pop_d;
    logic                push_d;

`ifdef INTERPO_COEF_READER_WRAP_EN
    assign start_ok_d  = (num_words != '0)
                       && (num_words <= (ADDR_W+1)'(DEPTH))
                       && (base_addr < ADDR_W'(DEPTH));
    assign next_addr_d = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
`else
    logic [ADDR_W+1:0]   end_d;
    assign end_d       = {2'b00, base_addr} + {1'b0, num_words};
    assign start_ok_d  = (num_words != '0) && (end_d <= (ADDR_W+2)'(DEPTH));
    assign next_addr_d = addr_q + 1'b1;
`endif

    // Words already buffered plus both read pipeline stages must leave room,
    // so a stalled sink can never overflow the FIFO.
    assign occ_d   = (c_CNT_W+1)'(count_q) + (c_CNT_W+1)'(cs_q) + (c_CNT_W+1)'(rv_q);
    assign issue_d = (state_q == READ) && (issued_q != num_q)
                   && (occ_d < (c_CNT_W+1)'(FIFO_DEPTH));
    assign push_d  = rv_q;
    assign pop_d   = src_valid && src_ready;

    assign src_valid                   = (count_q != '0);
    assign {src_sop, src_eop, src_data} = fifo_q[rd_ptr_q];
    assign busy           = busy_q;
    assign done           = done_q;
    assign cfg_err        = cfg_err_q;
    assign mem_address    = addr_q;
    assign mem_chipselect = cs_q;
    assign mem_clken      = 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            num_q     <= '0;
            issued_q  <= '0;
            wr_idx_q  <= '0;
            addr_q    <= '0;
            cs_q      <= 1'b0;
            rv_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            cs_q      <= 1'b0;
            rv_q      <= cs_q;

            if (push_d) begin
                fifo_q[wr_ptr_q] <= {(wr_idx_q == '0), (wr_idx_q == num_q - 1'b1), mem_readdata};
                wr_ptr_q         <= wr_ptr_q + 1'b1;
                wr_idx_q         <= wr_idx_q + 1'b1;
            end
            if (pop_d) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_d && !pop_d) begin
                count_q <= count_q + 1'b1;
            end else if (!push_d && pop_d) begin
                count_q <= count_q - 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (start_ok_d) begin
                            // First read goes out straight from the accept
                            // edge to reach the 2-cycle best-case latency.
                            num_q    <= num_words;
                            addr_q   <= base_addr;
                            cs_q     <= 1'b1;
                            issued_q <= {{ADDR_W{1'b0}}, 1'b1};
                            wr_idx_q <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= (num_words == {{ADDR_W{1'b0}}, 1'b1}) ? DRAIN : READ;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue_d) begin
                        cs_q     <= 1'b1;
                        addr_q   <= next_addr_d;
                        issued_q <= issued_q + 1'b1;
                        if (issued_q + 1'b1 == num_q) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!cs_q && !rv_q && (count_q == '0)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_interpo_coef_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_interpo_coef_reader
// Purpose  : Self-checking bench for interpo_coef_reader. A RAM model with
//            one cycle read latency feeds the DUT; expected beats are queued
//            from a block-level model and a monitor compares every transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interpo_coef_reader;

    localparam int DEP = 40;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [5:0]  base_addr;
    logic [6:0]  num_words;
    logic        busy, done, cfg_err;
    logic [5:0]  mem_address;
    logic        mem_chipselect, mem_clken;
    logic [31:0] mem_readdata;
    logic [31:0] src_data;
    logic        src_valid, src_ready, src_sop, src_eop;

    always #5 clk = ~clk;

    interpo_coef_reader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .num_words      (num_words),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_sop        (src_sop),
        .src_eop        (src_eop)
    );

    // Coefficient RAM: word[i] = C0DE0000 + i, registered read.
    logic [31:0] ram [DEP];
    initial begin
        for (int i = 0; i < DEP; i++) ram[i] = 32'hC0DE0000 + 32'(i);
        mem_readdata = '0;
    end
    always @(posedge clk) begin
        if (mem_chipselect)
            mem_readdata <= (int'(mem_address) < DEP) ? ram[mem_address] : 32'hDEADBEEF;
    end

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];
    int n_vec = 0, n_err = 0;
    int cs_cnt = 0, done_cnt = 0, err_cnt = 0, beat_cnt = 0, valid_cyc = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Block-level reference: legality rule and expected word stream.
    function automatic bit legal(int b, int n);
`ifdef INTERPO_COEF_READER_WRAP_EN
        return (n >= 1) && (n <= DEP) && (b < DEP);
`else
        return (n >= 1) && (b + n <= DEP);
`endif
    endfunction

    function automatic void push_expected(int b, int n);
        beat_t e;
        for (int k = 0; k < n; k++) begin
            e.sop  = (k == 0);
            e.eop  = (k == n - 1);
            e.data = 32'hC0DE0000 + 32'((b + k) % DEP);
            exp_q.push_back(e);
        end
    endfunction

    // Monitor: samples on the falling edge, pops on every accepted beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (mem_chipselect) begin
                    cs_cnt++;
                    check("addr_range", 64'(int'(mem_address) < DEP), 64'd1);
                end
                if (src_valid) valid_cyc++;
                if (done)      done_cnt++;
                if (cfg_err)   err_cnt++;
                if (src_valid && src_ready) begin
                    beat_cnt++;
                    check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("beat", 64'({src_sop, src_eop, src_data}), 64'(e));
                    end
                end
            end
        end
    end

    // Sink ready driver.
    initial begin
        src_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       src_ready = 1'b1;
                1:       src_ready = ($urandom_range(0, 3) != 0);
                default: src_ready = 1'b0;
            endcase
        end
    end

    task automatic issue_start(input int b, input int n);
        start     = 1'b1;
        base_addr = 6'(b);
        num_words = 7'(n);
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = 6'($urandom);
        num_words = 7'($urandom);
    endtask

    task automatic wait_done(input int d0);
        int ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_cnt > d0) begin
                ok = 1;
                break;
            end
        end
        check("done_seen", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input int b, input int n);
        int c0, d0, e0;
        c0 = cs_cnt; d0 = done_cnt; e0 = err_cnt;
        if (legal(b, n)) begin
            push_expected(b, n);
            issue_start(b, n);
            wait_done(d0);
            repeat (2) @(posedge clk);
            #1;
            check("done_once",   64'(done_cnt), 64'(d0 + 1));
            check("read_count",  64'(cs_cnt - c0), 64'(n));
            check("queue_empty", 64'(exp_q.size()), 64'd0);
            check("no_cfg_err",  64'(err_cnt), 64'(e0));
            check("idle_busy",   64'(busy), 64'd0);
        end else begin
            issue_start(b, n);
            @(negedge clk);
            check("cfg_err_pulse", 64'(cfg_err), 64'd1);
            check("rej_busy",      64'(busy), 64'd0);
            repeat (3) @(posedge clk);
            #1;
            check("rej_reads",     64'(cs_cnt - c0), 64'd0);
            check("rej_err_once",  64'(err_cnt), 64'(e0 + 1));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, d0, v0, b0, e0, ok;
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     64'(busy), 64'd0);
        check("rst_valid",    64'(src_valid), 64'd0);
        check("rst_cs",       64'(mem_chipselect), 64'd0);
        check("rst_clken",    64'(mem_clken), 64'd1);
        check("rst_data",     64'(src_data), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Block 5..8 with ready high: latency, back-to-back beats, 4 reads.
        ready_mode = 0;
        c0 = cs_cnt; d0 = done_cnt; v0 = valid_cyc;
        push_expected(5, 4);
        issue_start(5, 4);
        @(negedge clk);
        @(negedge clk);
        check("lat_not_yet", 64'(src_valid), 64'd0);
        @(negedge clk);
        check("lat_first",   64'(src_valid), 64'd1);
        wait_done(d0);
        check("t1_valid_cycles", 64'(valid_cyc - v0), 64'd4);
        check("t1_reads",        64'(cs_cnt - c0), 64'd4);
        check("t1_queue_empty",  64'(exp_q.size()), 64'd0);

        // Single-word block: sop and eop on the same beat.
        run_block(0, 1);

        // Full table with a stalled sink: only FIFO_DEPTH reads while stalled.
        ready_mode = 2;
        @(posedge clk);
        #1;
        c0 = cs_cnt; d0 = done_cnt; b0 = beat_cnt;
        push_expected(0, 40);
        issue_start(0, 40);
        repeat (19) @(posedge clk);
        @(negedge clk);
        check("stall_reads", 64'(cs_cnt - c0), 64'd4);
        check("stall_beats", 64'(beat_cnt - b0), 64'd0);
        check("stall_valid", 64'(src_valid), 64'd1);
        ready_mode = 0;
        @(posedge clk);
        #1;
        wait_done(d0);
        check("full_reads", 64'(cs_cnt - c0), 64'd40);
        check("full_beats", 64'(beat_cnt - b0), 64'd40);
        check("full_empty", 64'(exp_q.size()), 64'd0);

        // Block running off the end of the table, and zero-length block.
        run_block(38, 3);
        run_block(0, 0);

        // Second start while busy is ignored.
        c0 = cs_cnt; d0 = done_cnt; e0 = err_cnt;
        push_expected(10, 6);
        issue_start(10, 6);
        @(posedge clk);
        #1;
        issue_start(0, 2);
        wait_done(d0);
        repeat (5) @(posedge clk);
        #1;
        check("busy_start_reads", 64'(cs_cnt - c0), 64'd6);
        check("busy_start_noerr", 64'(err_cnt), 64'(e0));
        check("busy_start_empty", 64'(exp_q.size()), 64'd0);

        // Reset after 3 of 10 words.
        b0 = beat_cnt;
        push_expected(0, 10);
        issue_start(0, 10);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (beat_cnt - b0 >= 3) begin
                ok = 1;
                break;
            end
        end
        check("rst_mid_reach3", 64'(ok), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy",  64'(busy), 64'd0);
        check("arst_done",  64'(done), 64'd0);
        check("arst_err",   64'(cfg_err), 64'd0);
        check("arst_cs",    64'(mem_chipselect), 64'd0);
        check("arst_addr",  64'(mem_address), 64'd0);
        check("arst_clken", 64'(mem_clken), 64'd1);
        check("arst_valid", 64'(src_valid), 64'd0);
        check("arst_sop",   64'(src_sop), 64'd0);
        check("arst_eop",   64'(src_eop), 64'd0);
        check("arst_data",  64'(src_data), 64'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_block(3, 7);

        // Randomized blocks with a randomly stalling sink.
        ready_mode = 1;
        for (int i = 0; i < 14; i++) begin
            run_block(int'($urandom_range(0, 45)), int'($urandom_range(0, 42)));
        end
        ready_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
